// File: rtl/result_collector_pkg.sv
// Shared types and constants for the systolic-array result collector.
// Holds the default geometry, the FSM state enum and the skew convention.
package result_collector_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int BITS_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    // Lane i row r arrives at k = r + i, so every lane lines up at k = depth-1.
    function automatic int first_aligned(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/result_collector_skew_delay_line.sv
// En-gated shift register used to de-skew one collector lane.
// STAGES = 0 degenerates to a plain wire.
module skew_delay_line #(
    parameter int STAGES = 0,
    parameter int BITS   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    generate
        if (STAGES == 0) begin : g_thru
            logic w_unused;
            assign w_unused = clk ^ rst ^ en;
            assign q        = d;
        end else begin : g_pipe
            logic [BITS-1:0] r_stage [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < STAGES; s++) begin
                        r_stage[s] <= '0;
                    end
                end else if (en) begin
                    r_stage[0] <= d;
                    for (int s = 1; s < STAGES; s++) begin
                        r_stage[s] <= r_stage[s-1];
                    end
                end
            end

            assign q = r_stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/result_collector.sv
// De-skews rhombus-shaped systolic array outputs into a DEPTH x DEPTH
// row buffer and serves registered row reads by address.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int BITS  = BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic [BITS-1:0]          Cin  [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] Crow,
    output logic [BITS-1:0]          Cout [DEPTH],
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(2*DEPTH-1);

    localparam logic [KW-1:0] K_FIRST = KW'(first_aligned(DEPTH));
    localparam logic [KW-1:0] K_LAST  = KW'(2*DEPTH-2);

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [BITS-1:0] r_rowbuf [DEPTH][DEPTH];

    logic [BITS-1:0] w_aligned [DEPTH];
    logic            w_wr;
    logic [AW-1:0]   w_wr_row;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_lane
            skew_delay_line #(
                .STAGES(DEPTH-1-i),
                .BITS  (BITS)
            ) u_dl (
                .clk(clk),
                .rst(rst),
                .en (en),
                .d  (Cin[i]),
                .q  (w_aligned[i])
            );
        end
    endgenerate

    assign w_wr     = en && (r_state == COLLECT) && (r_k >= K_FIRST);
    assign w_wr_row = AW'(r_k - K_FIRST);

    // busy/done are decided alongside the state so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (en) begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= COLLECT;
                        r_k     <= KW'(1);
                        busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (r_k == K_LAST) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        r_state <= COLLECT;
                        r_k     <= KW'(1);
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_rowbuf[r][i] <= '0;
                end
            end
        end else if (w_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rowbuf[w_wr_row][i] <= w_aligned[i];
            end
        end
    end

    // Same-edge reads see the pre-write contents of the row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                Cout[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                Cout[i] <= r_rowbuf[Crow][i];
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: skewed tiles, stalls, restarts,
// mid-tile reset, back-to-back tiles and gated start.
module tb_result_collector;

    localparam int DEPTH = 8;
    localparam int BITS  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            start;
    logic [BITS-1:0] Cin  [DEPTH];
    logic [2:0]      Crow;
    logic [BITS-1:0] Cout [DEPTH];
    logic            busy;
    logic            done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    result_collector #(
        .DEPTH(DEPTH),
        .BITS (BITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .start(start),
        .Cin  (Cin),
        .Crow (Crow),
        .Cout (Cout),
        .busy (busy),
        .done (done)
    );

    function automatic logic [15:0] elem(input logic [15:0] base,
                                         input int r, input int i);
        return base + 16'(16*r + i);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [15:0] base, input int k);
        for (int i = 0; i < DEPTH; i++) begin
            if (k - i >= 0 && k - i < DEPTH) Cin[i] = elem(base, k - i, i);
            else Cin[i] = 16'hBEEF;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; start = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Feeds one skewed tile; lat = cycles from start cycle until done seen.
    task automatic drive_tile(input logic [15:0] base, input int stall_k,
                              input int stall_n, input int restart_k,
                              output int lat);
        int k;
        int left;
        k = 0; left = stall_n; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            set_lanes(base, k);
            if (k == stall_k && left > 0) begin
                en = 1'b0; start = 1'b0; left--;
            end else begin
                en = 1'b1; start = (k == 0) || (k == restart_k);
            end
            tick;
            if (en) k++;
            if (done) begin
                lat = c;
                break;
            end
        end
        en = 1'b1; start = 1'b0;
    endtask

    task automatic set_row(input int r);
        Crow = 3'(r);
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; start = 1'b0; Crow = '0;
        for (int i = 0; i < DEPTH; i++) Cin[i] = '0;
        tick;
        tick;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (Cout[i] !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_cout lane%0d: got %h want 0000", i, Cout[i]);
            end
        end
    endtask

    task automatic test_basic;
        int lat;
        drive_tile(16'h0000, -1, 0, -1, lat);
        vectors++;
        if (lat !== 15) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want 15", lat);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_flags: got busy=%b done=%b want 0 1", busy, done);
        end
        set_row(3);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (Cout[i] !== 16'(16'h30 + i)) begin
                miscompares++;
                $display("FAIL basic_row3 lane%0d: got %h want %h", i, Cout[i], 16'(16'h30 + i));
            end
        end
        for (int r = 0; r < DEPTH; r++) begin
            set_row(r);
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== elem(16'h0, r, i)) begin
                    miscompares++;
                    $display("FAIL basic_row r%0d lane%0d: got %h want %h", r, i, Cout[i], elem(16'h0, r, i));
                end
            end
        end
    endtask

    task automatic test_stall;
        int lat;
        do_reset;
        drive_tile(16'h0000, 5, 3, -1, lat);
        vectors++;
        if (lat !== 18) begin
            miscompares++;
            $display("FAIL stall_latency: got %0d want 18", lat);
        end
        for (int r = 0; r < DEPTH; r++) begin
            set_row(r);
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== elem(16'h0, r, i)) begin
                    miscompares++;
                    $display("FAIL stall_row r%0d lane%0d: got %h want %h", r, i, Cout[i], elem(16'h0, r, i));
                end
            end
        end
    endtask

    task automatic test_restart;
        int lat;
        do_reset;
        drive_tile(16'h0000, -1, 0, 6, lat);
        vectors++;
        if (lat !== 15) begin
            miscompares++;
            $display("FAIL restart_latency: got %0d want 15", lat);
        end
        for (int r = 0; r < DEPTH; r++) begin
            set_row(r);
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== elem(16'h0, r, i)) begin
                    miscompares++;
                    $display("FAIL restart_row r%0d lane%0d: got %h want %h", r, i, Cout[i], elem(16'h0, r, i));
                end
            end
        end
    endtask

    task automatic test_rst_mid;
        int lat;
        do_reset;
        Crow = 3'd0;
        for (int k = 0; k <= 8; k++) begin
            set_lanes(16'h0200, k);
            en = 1'b1; start = (k == 0);
            tick;
        end
        vectors++;
        if (Cout[0] !== 16'h0200 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got cout0=%h busy=%b want 0200 1", Cout[0], busy);
        end
        set_lanes(16'h0200, 9);
        rst = 1'b1; start = 1'b0;
        tick;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (Cout[i] !== 16'h0) begin
                miscompares++;
                $display("FAIL rstmid_cout lane%0d: got %h want 0000", i, Cout[i]);
            end
        end
        en = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            set_row(r);
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== 16'h0) begin
                    miscompares++;
                    $display("FAIL rstmid_zero r%0d lane%0d: got %h want 0000", r, i, Cout[i]);
                end
            end
        end
        drive_tile(16'h0000, -1, 0, -1, lat);
        vectors++;
        if (lat !== 15) begin
            miscompares++;
            $display("FAIL rstmid_fresh_latency: got %0d want 15", lat);
        end
        for (int r = 0; r < DEPTH; r++) begin
            set_row(r);
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== elem(16'h0, r, i)) begin
                    miscompares++;
                    $display("FAIL rstmid_fresh r%0d lane%0d: got %h want %h", r, i, Cout[i], elem(16'h0, r, i));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        Crow = 3'd7;
        for (int k = 0; k <= 14; k++) begin
            set_lanes(16'h0100, k);
            en = 1'b1; start = (k == 0);
            tick;
            if (k == 0) begin
                vectors++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_start: got busy=%b done=%b want 1 0", busy, done);
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== elem(16'h0, 7, i)) begin
                    miscompares++;
                    $display("FAIL b2b_old k%0d lane%0d: got %h want %h", k, i, Cout[i], elem(16'h0, 7, i));
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: got busy=%b done=%b want 0 1", busy, done);
        end
        set_lanes(16'h0100, 15);
        start = 1'b0;
        tick;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (Cout[i] !== elem(16'h0100, 7, i)) begin
                miscompares++;
                $display("FAIL b2b_new lane%0d: got %h want %h", i, Cout[i], elem(16'h0100, 7, i));
            end
        end
        for (int r = 0; r < DEPTH; r++) begin
            set_row(r);
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (Cout[i] !== elem(16'h0100, r, i)) begin
                    miscompares++;
                    $display("FAIL b2b_row r%0d lane%0d: got %h want %h", r, i, Cout[i], elem(16'h0100, r, i));
                end
            end
        end
    endtask

    task automatic test_start_no_en;
        do_reset;
        en = 1'b0; start = 1'b1;
        tick;
        tick;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL noen_hold: got busy=%b done=%b want 0 0", busy, done);
        end
        en = 1'b1; start = 1'b0;
        tick;
        tick;
        tick;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL noen_after: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_restart;
        test_rst_mid;
        test_back_to_back;
        test_start_no_en;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
